// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 16x-oversampled 8-data/odd-parity/1-stop UART receiver with a 4-entry newest-first buffer.
// Define RX_PARITY_CHECK_EN to discard bad-parity frames and pulse parity_err.
`timescale 1ns/1ps

module uart_rx_buffer #(
    parameter int OVS_DIV = 651
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    input  logic            clr,
    output logic [3:0][7:0] Rdatas,
    output logic [7:0]      led,
    output logic [2:0]      count,
    output logic            rx_valid,
    output logic            parity_err,
    output logic            frame_err,
    output logic            overrun,
    output logic            busy
);
    localparam int TW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic          rxs_prev;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          tick;
    logic          sample;
    logic          stop_ok;
    logic          parity_good;
    logic          accept;

    assign tick        = (tick_cnt == TICK_LAST);
    assign sample      = tick && (phase == 4'd7);
    assign stop_ok     = (state == STOP) && sample && rxs;
    assign parity_good = ^{shift_reg, parity_bit};
    assign led         = Rdatas[0];

`ifdef RX_PARITY_CHECK_EN
    assign accept = stop_ok && parity_good;
`else
    // Parity is still captured but never gates acceptance.
    logic unused_parity;
    assign accept        = stop_ok;
    assign parity_err    = 1'b0;
    assign unused_parity = &{1'b0, parity_good};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rxs_prev   <= 1'b1;
            tick_cnt   <= '0;
            phase      <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            Rdatas     <= '0;
            count      <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            rxs_prev  <= rxs;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif

            // Counters sit at zero in IDLE so they start fresh on entry to START.
            if (state == IDLE) begin
                tick_cnt <= '0;
                phase    <= '0;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                if (tick) begin
                    phase <= phase + 4'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (rxs_prev && !rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (sample) begin
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (sample) begin
                        parity_bit <= rxs;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (sample) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= !rxs;
`ifdef RX_PARITY_CHECK_EN
                        parity_err <= rxs && !parity_good;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A clear coinciding with an accept leaves only the new byte.
            if (accept) begin
                rx_valid <= 1'b1;
                if (clr) begin
                    Rdatas <= {8'h00, 8'h00, 8'h00, shift_reg};
                    count  <= 3'd1;
                end else begin
                    Rdatas <= {Rdatas[2:0], shift_reg};
                    if (count == 3'd4) begin
                        overrun <= 1'b1;
                    end else begin
                        count <= count + 3'd1;
                    end
                end
            end else if (clr) begin
                Rdatas <= '0;
                count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed testbench for uart_rx_buffer at OVS_DIV=4 (64 clk per bit).
// Expectations follow RX_PARITY_CHECK_EN when the macro is defined for the build.
`timescale 1ns/1ps

module tb_uart_rx_buffer;
    localparam int OVS      = 4;
    localparam int BIT_CLKS = 16 * OVS;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx;
    logic            clr;
    logic [3:0][7:0] Rdatas;
    logic [7:0]      led;
    logic [2:0]      count;
    logic            rx_valid;
    logic            parity_err;
    logic            frame_err;
    logic            overrun;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_ovr = 0, n_ovr_valid = 0;
    int b_valid = 0, b_perr = 0, b_ferr = 0, b_ovr = 0, b_ovr_valid = 0;
    int valid_cyc = 0;
    int start_cyc = 0;
    int lat       = 0;

    uart_rx_buffer #(.OVS_DIV(OVS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .clr        (clr),
        .Rdatas     (Rdatas),
        .led        (led),
        .count      (count),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse outputs are tallied in high cycles, so a wide pulse shows up as an extra count.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (parity_err) n_perr = n_perr + 1;
        if (frame_err)  n_ferr = n_ferr + 1;
        if (overrun)    n_ovr  = n_ovr + 1;
        if (overrun && rx_valid) n_ovr_valid = n_ovr_valid + 1;
    end

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic mark();
        b_valid     = n_valid;
        b_perr      = n_perr;
        b_ferr      = n_ferr;
        b_ovr       = n_ovr;
        b_ovr_valid = n_ovr_valid;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives the first nbits of a frame then 32 idle-high clocks; clr_lat>0 raises clr for exactly one accept edge.
    task automatic applyStimulus(input logic [7:0] data, input logic p, input logic stop,
                                 input int nbits, input int clr_lat);
        logic [10:0] frame;
        frame = {stop, p, data, 1'b0};
        for (int n = 0; n < nbits * BIT_CLKS + 32; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) start_cyc = cyc;
            if (n % BIT_CLKS == 0) rx = (n / BIT_CLKS < nbits) ? frame[n / BIT_CLKS] : 1'b1;
            if (clr_lat > 0) clr = (cyc == start_cyc + clr_lat - 1);
        end
        clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] data);
        applyStimulus(data, odd_par(data), 1'b1, 11, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdatas", Rdatas, 32'h0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_pulses", 32'({rx_valid, parity_err, frame_err, overrun}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        $display("[TB] single byte 0xA5");
        mark();
        send(8'hA5);
        lat = valid_cyc - start_cyc;
        if (lat <= 0 || lat > 2000) lat = 675;
        checkOutput("a5_rdatas0", 32'(Rdatas[0]), 32'hA5);
        checkOutput("a5_led", 32'(led), 32'hA5);
        checkOutput("a5_count", 32'(count), 32'd1);
        checkOutput("a5_valid_pulses", 32'(n_valid - b_valid), 32'd1);
        checkOutput("a5_err_pulses", 32'((n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr)), 32'd0);
        checkOutput("a5_busy", 32'(busy), 32'd0);

        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        checkOutput("clr_rdatas", Rdatas, 32'h0);
        checkOutput("clr_count", 32'(count), 32'd0);

        $display("[TB] fill and overrun");
        mark();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        checkOutput("fill4_count", 32'(count), 32'd4);
        checkOutput("fill4_overrun", 32'(n_ovr - b_ovr), 32'd0);
        send(8'h55);
        checkOutput("fill5_rdatas", Rdatas, 32'h22334455);
        checkOutput("fill5_count", 32'(count), 32'd4);
        checkOutput("fill5_overrun", 32'(n_ovr - b_ovr), 32'd1);
        checkOutput("fill5_ovr_with_valid", 32'(n_ovr_valid - b_ovr_valid), 32'd1);
        checkOutput("fill5_valid", 32'(n_valid - b_valid), 32'd5);

        $display("[TB] bad parity 0x0F");
        mark();
        applyStimulus(8'h0F, ~odd_par(8'h0F), 1'b1, 11, 0);
`ifdef RX_PARITY_CHECK_EN
        checkOutput("par_perr", 32'(n_perr - b_perr), 32'd1);
        checkOutput("par_valid", 32'(n_valid - b_valid), 32'd0);
        checkOutput("par_rdatas", Rdatas, 32'h22334455);
        checkOutput("par_count", 32'(count), 32'd4);
`else
        checkOutput("par_perr", 32'(n_perr - b_perr), 32'd0);
        checkOutput("par_valid", 32'(n_valid - b_valid), 32'd1);
        checkOutput("par_rdatas", Rdatas, 32'h3344550F);
        checkOutput("par_count", 32'(count), 32'd4);
`endif

        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;

        $display("[TB] framing error then recovery");
        mark();
        applyStimulus(8'h3C, odd_par(8'h3C), 1'b0, 11, 0);
        checkOutput("frm_ferr", 32'(n_ferr - b_ferr), 32'd1);
        checkOutput("frm_valid", 32'(n_valid - b_valid), 32'd0);
        checkOutput("frm_rdatas", Rdatas, 32'h0);
        send(8'h3C);
        checkOutput("frm_next_rdatas", Rdatas, 32'h0000003C);
        checkOutput("frm_next_count", 32'(count), 32'd1);

        $display("[TB] 20-clk glitch");
        mark();
        @(posedge clk); #1 rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("glitch_busy_mid", 32'(busy), 32'd1);
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        checkOutput("glitch_busy_end", 32'(busy), 32'd0);
        checkOutput("glitch_pulses", 32'((n_valid - b_valid) + (n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr)), 32'd0);
        checkOutput("glitch_count", 32'(count), 32'd1);

        $display("[TB] reset during data bit 4");
        applyStimulus(8'h7E, odd_par(8'h7E), 1'b1, 5, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_rdatas", Rdatas, 32'h0);
        checkOutput("midrst_led", 32'(led), 32'h0);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_pulses", 32'({rx_valid, parity_err, frame_err, overrun}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        mark();
        send(8'h7E);
        checkOutput("postrst_rdatas", Rdatas, 32'h0000007E);
        checkOutput("postrst_count", 32'(count), 32'd1);
        checkOutput("postrst_valid", 32'(n_valid - b_valid), 32'd1);

        $display("[TB] clear coincident with accept");
        send(8'h01);
        send(8'h02);
        send(8'h03);
        checkOutput("pre_clr_rdatas", Rdatas, 32'h7E010203);
        mark();
        applyStimulus(8'h5A, odd_par(8'h5A), 1'b1, 11, lat);
        checkOutput("clracc_rdatas", Rdatas, 32'h0000005A);
        checkOutput("clracc_count", 32'(count), 32'd1);
        checkOutput("clracc_valid", 32'(n_valid - b_valid), 32'd1);
        checkOutput("clracc_overrun", 32'(n_ovr - b_ovr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
